ls_functional_unit: RTL

Load/store functional unit that receives issued entries from the LS reservation station. It is the consumer side of the RS-to-FU issue interface: it asserts ready, accepts start/op/operands, and performs one data-memory access through a req/ack handshake. It returns the completed result to the ROB with a done/ready handshake. At most one operation is in flight at a time.

---
 rtl/ls_functional_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ls_functional_unit.sv
// Load/store functional unit: accepts one RS issue, runs a single data-memory req/ack access, returns the result to the ROB.
// Optional misaligned-access fault: define LS_MISALIGN_CHECK_EN.

localparam int unsigned GPR_SIZE     = 64;
localparam int unsigned ROB_IDX_SIZE = 6;

typedef enum logic [1:0] {
    FU_OP_NOP  = 2'd0,
    FU_OP_ADD  = 2'd1,
    FU_OP_LDUR = 2'd2,
    FU_OP_STUR = 2'd3
} fu_op_t;

module ls_functional_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_rs_start,
    input  fu_op_t                  in_rs_op,
    input  logic [GPR_SIZE-1:0]     in_rs_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
    input  logic                    in_rob_is_mispred,
    output logic                    out_rs_ready,
    output logic                    out_mem_req,
    output logic                    out_mem_we,
    output logic [GPR_SIZE-1:0]     out_mem_addr,
    output logic [GPR_SIZE-1:0]     out_mem_wdata,
    input  logic                    in_mem_ack,
    input  logic [GPR_SIZE-1:0]     in_mem_rdata,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_fault,
    input  logic                    in_rob_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    fu_op_t                  op_q;
    logic [GPR_SIZE-1:0]     addr_q;
    logic [GPR_SIZE-1:0]     wdata_q;
    logic [ROB_IDX_SIZE-1:0] dst_q;
    logic [GPR_SIZE-1:0]     value_q;
    logic                    fault_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    squash_q;

    logic accept;
    logic is_mem_op;
    logic misalign;
    logic timeout;
    logic kill;

    assign accept    = in_rs_start & out_rs_ready;
    assign is_mem_op = (in_rs_op == FU_OP_LDUR) || (in_rs_op == FU_OP_STUR);
    // Ack in the final counted cycle takes priority over the timeout.
    assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) & ~in_mem_ack;
    assign kill      = squash_q | in_rob_is_mispred;

`ifdef LS_MISALIGN_CHECK_EN
    assign misalign = (in_rs_val_a[2:0] != 3'd0);
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (is_mem_op && !misalign) ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                if (in_mem_ack || timeout) begin
                    state_d = kill ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (in_rob_ready || in_rob_is_mispred) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        out_rs_ready  = 1'b0;
        out_mem_req   = 1'b0;
        out_mem_we    = 1'b0;
        out_rob_done  = 1'b0;
        out_rob_fault = 1'b0;
        case (state_q)
            ST_IDLE: out_rs_ready = ~in_rob_is_mispred;
            ST_REQ: begin
                out_mem_req = 1'b1;
                out_mem_we  = (op_q == FU_OP_STUR);
            end
            ST_RESP: begin
                out_rob_done  = 1'b1;
                out_rob_fault = fault_q;
            end
            default: ;
        endcase
    end

    assign out_mem_addr          = addr_q;
    assign out_mem_wdata         = wdata_q;
    assign out_rob_dst_rob_index = dst_q;
    assign out_rob_value         = value_q;

    // Issue capture, access completion, timeout count and squash tracking
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            op_q     <= FU_OP_NOP;
            addr_q   <= '0;
            wdata_q  <= '0;
            dst_q    <= '0;
            value_q  <= '0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
            squash_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= in_rs_op;
                addr_q  <= in_rs_val_a;
                wdata_q <= in_rs_val_b;
                dst_q   <= in_rs_dst_rob_index;
                value_q <= '0;
                fault_q <= ~(is_mem_op & ~misalign);
                cnt_q   <= '0;
            end
            if (state_q == ST_REQ) begin
                if (in_mem_ack) begin
                    value_q <= (op_q == FU_OP_LDUR) ? in_mem_rdata : '0;
                    fault_q <= 1'b0;
                end else if (timeout) begin
                    value_q <= '0;
                    fault_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (state_d == ST_IDLE) begin
                squash_q <= 1'b0;
            end else if (state_q == ST_REQ && in_rob_is_mispred) begin
                squash_q <= 1'b1;
            end
        end
    end

endmodule
